frame_buffer_writer: RTL
========================

Name: frame_buffer_writer

Overview:
Writer side of the 240x320 card frame buffer that find_corners and card_isolator read.
- Takes an RGB565 camera pixel stream with coordinates and thresholds each pixel to pure black (16'h0000) or white (16'hFFFF).
- Writes one full frame into the single-port read-first BRAM at addr = y*WIDTH + x.
- A one-cycle capture request arms it. It writes exactly one frame and then pulses done, which lets the corner-finding pass start.

Parameters:
- WIDTH, 240, frame width in pixels; x coordinate is 8 bits.
- HEIGHT, 320, frame height in pixels; y coordinate is 9 bits.
- THRESHOLD, 8'd96, brightness at or above which a pixel becomes white.

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- capture_flag  input  1  one-cycle request to capture the next full frame.
- pixel_valid_in  input  1  qualifies pixel_data_in, hcount_in and vcount_in this cycle.
- hcount_in  input  9  pixel x coordinate (may exceed WIDTH-1).
- vcount_in  input  9  pixel y coordinate (may exceed HEIGHT-1).
- pixel_data_in  input  16  RGB565 pixel: R[15:11], G[10:5], B[4:0].
- addr_out  output  17  BRAM write address.
- data_out  output  16  BRAM write data, 16'h0000 or 16'hFFFF only.
- we_out  output  1  BRAM write enable.
- busy_out  output  1  high from accepted capture until the last write has issued.
- frame_done_out  output  1  one-cycle pulse in the cycle after the final write.

Behaviour:
- Reset values: addr_out=0, data_out=0, we_out=0, busy_out=0, frame_done_out=0, state=IDLE.
- Brightness: sum = {R,1'b0} + G + {B,1'b0}, computed 8 bits wide (maximum 187, no overflow).
  - White when sum >= THRESHOLD, black otherwise.
- Address: vcount*WIDTH + hcount, computed 17 bits wide. Maximum is 76799.
- Write pipeline has latency 1: pixel accepted in cycle N gives we_out/addr_out/data_out registered in cycle N+1.
- In-frame pixel: pixel_valid_in=1 && hcount_in < WIDTH && vcount_in < HEIGHT. Any other cycle produces we_out=0 in the next cycle.
- States:
  - IDLE: busy_out=0. capture_flag moves to WAIT_SOF, busy_out=1 from the next cycle.
  - WAIT_SOF: discards all pixels until a valid pixel at (0,0). That pixel is accepted and the state moves to CAPTURE. A capture that arrives mid-frame therefore never yields a partial frame.
  - CAPTURE: writes every in-frame pixel. Accepting pixel (WIDTH-1, HEIGHT-1) moves to DONE.
  - DONE, one cycle: the final write is on the bus. Next cycle frame_done_out=1 and busy_out=0, then back to IDLE.
- capture_flag while busy is ignored. It is not queued.
- A new (0,0) during CAPTURE, i.e. the source restarted before the last pixel, restarts the frame at address 0. Capture stays in CAPTURE and does not pulse done.
- The bus is held between writes: addr_out and data_out keep their last values when we_out=0.
- Reset mid-frame: next cycle we_out=0, busy_out=0, state=IDLE. Frame contents are left undefined.
- Out-of-range coordinates (e.g. hcount up to 319 in blanking) never write and never wrap.

Decomposition:
- Package fb_writer_pkg holds:
  - state enum fb_state_t {IDLE, WAIT_SOF, CAPTURE, DONE};
  - RGB565 field slice constants;
  - BLACK/WHITE 16-bit constants.
- Sub-module rgb565_thresh: combinational brightness and compare, parameter THRESHOLD, output one bit. It is reused later for live preview.

Test Plan:
1. Reset for 2 cycles -> all outputs 0. Then capture_flag=1 for one cycle -> busy_out=1 next cycle, state WAIT_SOF.
2. Thresholds with THRESHOLD=96:
   - pixel 16'h0000 -> data_out 16'h0000.
   - 16'hFFFF (sum 187) -> 16'hFFFF.
   - R=16, G=32, B=16 (sum 96) -> 16'hFFFF.
   - R=16, G=31, B=16 (sum 95) -> 16'h0000.
   - Each write lands 1 cycle after its valid pixel.
3. Full 240x320 raster with 80 blanking columns (hcount 240..319) per line:
   - exactly 76800 we_out pulses;
   - first addr 0, (1,0) -> 1, (0,1) -> 240, last addr 76799;
   - frame_done_out pulses once, 1 cycle after the last write.
4. capture_flag asserted mid-frame at (100,50) -> no writes until the next (0,0), then a full frame. A second capture_flag during CAPTURE is ignored.
5. rst_in asserted at pixel (10,200) -> we_out=0 and busy_out=0 next cycle. A new capture then writes a full frame starting at address 0.
6. pixel_valid_in deasserted for 3 cycles mid-line, then resumed -> no writes during the gap and correct addresses after it. The memory image matches the golden thresholded .mem file.

Source files
------------

// File: rtl/fb_writer_pkg.sv
// Shared types and constants for the card frame buffer writer.
package fb_writer_pkg;

  // Writer control states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } fb_state_t;

  // RGB565 field positions.
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // Frame buffer address width (240*320 = 76800 words).
  localparam int ADDR_W = 17;

  // The buffer only ever holds pure black or pure white.
  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;

endpackage

// File: rtl/frame_buffer_writer_if.sv
// Pixel stream in / BRAM write port out of the frame buffer writer.
//
// Handshake: the pixel stream has no backpressure. A pixel (pixel_data_in,
// hcount_in, vcount_in) is transferred in every cycle where pixel_valid_in is
// high and is ignored otherwise. capture_flag is a single-cycle request. On the
// BRAM side a word is written in every cycle where we_out is high; addr_out and
// data_out hold their last values while we_out is low.
interface frame_buffer_writer_if;
  import fb_writer_pkg::*;

  logic              capture_flag;
  logic              pixel_valid_in;
  logic [8:0]        hcount_in;
  logic [8:0]        vcount_in;
  logic [15:0]       pixel_data_in;
  logic [ADDR_W-1:0] addr_out;
  logic [15:0]       data_out;
  logic              we_out;
  logic              busy_out;
  logic              frame_done_out;

  // Writer side.
  modport slave (
    input  capture_flag, pixel_valid_in, hcount_in, vcount_in, pixel_data_in,
    output addr_out, data_out, we_out, busy_out, frame_done_out
  );

  // Camera / controller side.
  modport master (
    output capture_flag, pixel_valid_in, hcount_in, vcount_in, pixel_data_in,
    input  addr_out, data_out, we_out, busy_out, frame_done_out
  );

endinterface

// File: rtl/rgb565_thresh.sv
// Combinational RGB565 brightness threshold: 2R + G + 2B >= THRESHOLD.
// Also used by the live preview path, so it stays free of any state.
module rgb565_thresh
  import fb_writer_pkg::*;
#(
  parameter logic [7:0] THRESHOLD = 8'd96
) (
  input  logic [15:0] pixel,
  output logic        white
);

  logic [7:0] sum;

  // Doubling R and B brings their 5-bit range up to G's 6-bit range;
  // the worst case 62 + 63 + 62 = 187 fits in 8 bits.
  always_comb begin
    sum   = {2'b00, pixel[R_MSB:R_LSB], 1'b0}
          + {2'b00, pixel[G_MSB:G_LSB]}
          + {2'b00, pixel[B_MSB:B_LSB], 1'b0};
    white = (sum >= THRESHOLD);
  end

endmodule

// File: rtl/frame_buffer_writer.sv
// Captures one thresholded frame into the card frame buffer on request.
// Waits for a start of frame so a mid-frame request never yields a partial
// image, writes every in-frame pixel at y*WIDTH + x, then pulses done.
module frame_buffer_writer
  import fb_writer_pkg::*;
#(
  parameter int         WIDTH     = 240,
  parameter int         HEIGHT    = 320,
  parameter logic [7:0] THRESHOLD = 8'd96
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  frame_buffer_writer_if.slave  bus,
  output fb_state_t             state_out
);

  localparam logic [8:0]        X_END      = 9'(WIDTH);
  localparam logic [8:0]        Y_END      = 9'(HEIGHT);
  localparam logic [8:0]        X_LAST     = 9'(WIDTH - 1);
  localparam logic [8:0]        Y_LAST     = 9'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(WIDTH);

  fb_state_t         state, next_state;
  logic              in_frame, is_sof, is_last, accept, white;
  logic [ADDR_W-1:0] pix_addr;

  logic              we_q, busy_q, done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;

  rgb565_thresh #(.THRESHOLD(THRESHOLD)) u_thresh (
    .pixel (bus.pixel_data_in),
    .white (white)
  );

  // Pixel classification and linear address of the incoming pixel.
  always_comb begin
    in_frame = bus.pixel_valid_in && (bus.hcount_in < X_END) && (bus.vcount_in < Y_END);
    is_sof   = bus.pixel_valid_in && (bus.hcount_in == 9'd0) && (bus.vcount_in == 9'd0);
    is_last  = in_frame && (bus.hcount_in == X_LAST) && (bus.vcount_in == Y_LAST);
    pix_addr = {8'd0, bus.vcount_in} * ROW_STRIDE + {8'd0, bus.hcount_in};
  end

  // Next-state and pixel-accept decode. A (0,0) seen during CAPTURE is simply
  // written at address 0, which restarts the frame without leaving CAPTURE.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.capture_flag) next_state = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (is_sof) begin
          accept     = 1'b1;
          next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        accept = in_frame;
        if (is_last) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register and registered BRAM write port / status outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= BLACK;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      we_q   <= accept;
      if (accept) begin
        addr_q <= pix_addr;
        data_q <= white ? WHITE : BLACK;
      end
      busy_q <= (next_state != IDLE);
      done_q <= (state == DONE);
    end
  end

  assign bus.we_out         = we_q;
  assign bus.addr_out       = addr_q;
  assign bus.data_out       = data_q;
  assign bus.busy_out       = busy_q;
  assign bus.frame_done_out = done_q;
  assign state_out          = state;

endmodule
